scan_sequencer: RTL and testbench
=================================

Name: scan_sequencer

Overview:
Top-level controller for the cube colour scan. It steps the move-batch generator through its step index, waits for the motor executor to finish each batch, lets the cube settle mechanically, and then asks the colour sensor to sample one sticker. It sits between the move-batch generator (`send_setup_moves`/`counter`/`new_moves`), the motor executor (`exec_start`/`exec_done`) and the colour-sensor front end (`observe_req`/`observe_ack`).

Parameters:
LAST_STEP, 48, final step index. Steps 0..LAST_STEP-1 are observation steps; step LAST_STEP is the restore batch and has no observation.
SETTLE_CYCLES, 50000, clock cycles to wait after `exec_done` before raising `observe_req`. Must be at least 1.
GEN_TIMEOUT, 16, maximum cycles to wait for `new_moves` after a request before flagging an error.

Ports:
clock  input  1  system clock, all logic on posedge.
reset  input  1  asynchronous, active-high; clears all state.
start  input  1  one-cycle pulse that begins a scan; ignored unless in IDLE.
abort  input  1  synchronous; forces a return to IDLE from any state.
send_setup_moves  output  1  one-cycle pulse requesting the batch for the current `counter`.
counter  output  6  current step index, 0..LAST_STEP.
new_moves  input  1  generator pulse: the moves register holds a valid batch.
exec_start  output  1  one-cycle pulse telling the executor to run the latched batch.
exec_done  input  1  executor pulse: batch finished. An empty batch still produces a pulse.
observe_req  output  1  level; sensor should sample sticker number `counter`.
observe_ack  input  1  sensor has captured the sample.
busy  output  1  high in every state except IDLE.
scan_done  output  1  one-cycle pulse when the restore batch completes.
error  output  1  sticky generator-timeout flag; cleared only by the next accepted `start` or by reset.

Behaviour:
- Reset (asynchronous): state=IDLE; `counter`=0; `settle_cnt`=0; `timeout_cnt`=0; every output is 0.
- States: IDLE, REQ, WAIT_GEN, WAIT_EXEC, SETTLE, OBSERVE, ADVANCE, DONE.
- IDLE: on `start`, set `counter`=0 and `error`=0, then go to REQ. `busy`=0.
- REQ: assert `send_setup_moves` for exactly one cycle, clear `timeout_cnt`, go to WAIT_GEN.
- WAIT_GEN:
  - On `new_moves`: pulse `exec_start` in the next cycle and go to WAIT_EXEC.
  - Otherwise increment `timeout_cnt`. When `timeout_cnt` reaches GEN_TIMEOUT, set `error`=1 and go to IDLE.
- WAIT_EXEC: on `exec_done`:
  - if `counter`==LAST_STEP, go to DONE;
  - otherwise load `settle_cnt`=SETTLE_CYCLES-1 and go to SETTLE.
  - `exec_done` in the same cycle as the `exec_start` pulse is accepted.
- SETTLE: decrement `settle_cnt`; when it reaches 0, go to OBSERVE. Exactly SETTLE_CYCLES cycles are spent in SETTLE.
- OBSERVE:
  - `observe_req` is high from entry until the cycle in which `observe_ack` is sampled high.
  - `observe_req` falls on the following edge; then go to ADVANCE.
  - `counter` is stable throughout OBSERVE.
- ADVANCE: `counter`<=`counter`+1 (6-bit, never exceeds LAST_STEP), go to REQ.
- DONE: pulse `scan_done` for one cycle, go to IDLE. `counter` holds LAST_STEP until the next `start`.
- Latency:
  - `start` to `send_setup_moves`: 2 cycles.
  - `exec_done` to `observe_req`: SETTLE_CYCLES+1 cycles.
  - `observe_ack` to next `send_setup_moves`: 3 cycles.
- `abort`:
  - Highest priority after reset; valid in any state.
  - Next state is IDLE, with `observe_req`, `exec_start`, `send_setup_moves` and `busy` driven 0 in that cycle.
  - `counter` and `error` are held.
- `start` and `abort` in the same cycle in IDLE: `abort` wins and the block stays in IDLE.
- Stray `new_moves`, `exec_done` or `observe_ack` outside their waiting state are ignored.
- `observe_ack` held high across multiple cycles advances only once.
- Reset mid-scan returns the block to IDLE immediately. A scan after reset must start with `start`.

Test Plan:
1. Full scan: LAST_STEP=48, SETTLE_CYCLES=4. Generator model echoes `new_moves` 1 cycle after request; executor returns `exec_done` 3 cycles after `exec_start`; sensor acks 2 cycles after `observe_req`. Required: 49 `send_setup_moves` pulses, 48 `observe_req` windows with `counter`=0..47 in order, exactly one `scan_done` after step 48's `exec_done`, then `busy`=0.
2. Settle timing: `exec_done` at cycle T. Required: `observe_req` rises at T+5 exactly, with SETTLE_CYCLES=4.
3. Generator timeout: never assert `new_moves` at step 3. Required: `error`=1 at cycle 16 after the request, state IDLE, `counter`=3. A following `start` clears `error` and sets `counter`=0.
4. Abort during OBSERVE at step 10. Required: `observe_req`=0 and `busy`=0 the next cycle, `counter` stays 10, and a late `observe_ack` causes no change.
5. Async reset asserted mid-SETTLE (not on a clock edge). Required: all outputs 0 and `counter`=0 before the next posedge. Pulsing `start` restarts the scan from step 0.
6. Held `observe_ack` for 5 cycles at step 7. Required: `counter` increments once to 8, and exactly one `send_setup_moves` is issued.

Source files
------------

// File: rtl/scan_sequencer_if.sv
// Handshake bundle between the scan sequencer and the generator, executor and colour sensor.
interface scan_sequencer_if;
  logic       send_setup_moves;
  logic [5:0] counter;
  logic       new_moves;
  logic       exec_start;
  logic       exec_done;
  logic       observe_req;
  logic       observe_ack;

  modport master (
    output send_setup_moves, counter, exec_start, observe_req,
    input  new_moves, exec_done, observe_ack
  );

  modport slave (
    input  send_setup_moves, counter, exec_start, observe_req,
    output new_moves, exec_done, observe_ack
  );
endinterface

// File: rtl/scan_sequencer.sv
// Cube colour-scan controller: request batch, execute, settle, observe, advance; final step restores the cube.
module scan_sequencer #(
  parameter int LAST_STEP     = 48,
  parameter int SETTLE_CYCLES = 50000,
  parameter int GEN_TIMEOUT   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  scan_sequencer_if.master  bus,
  output logic              busy,
  output logic              scan_done,
  output logic              error
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = $clog2(GEN_TIMEOUT + 1);
  localparam logic [5:0]    LAST        = 6'(LAST_STEP);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(GEN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT_GEN, WAIT_EXEC, SETTLE, OBSERVE, ADVANCE, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    counter_q, counter_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [TW-1:0] timeout_cnt_q, timeout_cnt_d;
  logic          error_q, error_d;
  logic          send_q, send_d;
  logic          exec_start_q, exec_start_d;
  logic          observe_q, observe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      counter_q     <= '0;
      settle_cnt_q  <= '0;
      timeout_cnt_q <= '0;
      error_q       <= 1'b0;
      send_q        <= 1'b0;
      exec_start_q  <= 1'b0;
      observe_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      settle_cnt_q  <= settle_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      error_q       <= error_d;
      send_q        <= send_d;
      exec_start_q  <= exec_start_d;
      observe_q     <= observe_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    settle_cnt_d  = settle_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    error_d       = error_q;
    case (state_q)
      IDLE: if (start) begin
        counter_d = '0;
        error_d   = 1'b0;
        state_d   = REQ;
      end
      REQ: begin
        timeout_cnt_d = '0;
        state_d       = WAIT_GEN;
      end
      WAIT_GEN: begin
        if (bus.new_moves) begin
          state_d = WAIT_EXEC;
        end else begin
          timeout_cnt_d = timeout_cnt_q + TW'(1);
          if (timeout_cnt_q == TMO_LAST) begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_EXEC: if (bus.exec_done) begin
        if (counter_q == LAST) begin
          state_d = DONE;
        end else begin
          settle_cnt_d = SETTLE_INIT;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == '0) state_d = OBSERVE;
        else                    settle_cnt_d = settle_cnt_q - SW'(1);
      end
      OBSERVE: if (bus.observe_ack) state_d = ADVANCE;
      ADVANCE: begin
        counter_d = (counter_q == LAST) ? counter_q : counter_q + 6'd1;
        state_d   = REQ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides everything; step index and error flag are preserved.
    if (abort) begin
      state_d   = IDLE;
      counter_d = counter_q;
      error_d   = error_q;
    end
    // Outputs are registered off the upcoming state so they change on the transition edge.
    send_d       = (state_q == REQ)      && (state_d == WAIT_GEN);
    exec_start_d = (state_q == WAIT_GEN) && (state_d == WAIT_EXEC);
    observe_d    = (state_d == OBSERVE);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
  end

  assign bus.send_setup_moves = send_q;
  assign bus.counter          = counter_q;
  assign bus.exec_start       = exec_start_q;
  assign bus.observe_req      = observe_q;
  assign busy                 = busy_q;
  assign scan_done            = done_q;
  assign error                = error_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Randomized-latency environment for scan_sequencer, checked against cycle arithmetic derived from the scan rules.
module tb_scan_sequencer;
  localparam int LAST   = 48;
  localparam int SETTLE = 4;
  localparam int TMO    = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, scan_done, error;

  scan_sequencer_if sif();

  scan_sequencer #(.LAST_STEP(LAST), .SETTLE_CYCLES(SETTLE), .GEN_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .bus(sif.master), .busy(busy), .scan_done(scan_done), .error(error)
  );

  always #5 clock = ~clock;

  int   nchk = 0, nerr = 0, cyc = 0;
  int   n_send = 0, n_obs = 0;
  logic obs_prev = 1'b0;

  always @(negedge clock) begin
    if (sif.send_setup_moves) n_send++;
    if (sif.observe_req && !obs_prev) n_obs++;
    obs_prev = sif.observe_req;
  end

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return sif.send_setup_moves;
      1:       return sif.exec_start;
      2:       return sif.observe_req;
      3:       return error;
      default: return scan_done;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, output int at);
    int n = 0;
    while (!sig(sel) && n < budget) begin
      tick();
      n++;
    end
    at = sig(sel) ? cyc : -1000;
  endtask

  task automatic do_start(output int c);
    start = 1'b1;
    c = cyc;
    tick();
    start = 1'b0;
  endtask

  // mode 0: full step, 1: return at observe_req rise, 2: return the cycle after exec_done
  task automatic do_step(input int s, input int ref_cyc, input int lat, input int mode, output int t_out);
    int at, gl, el, al, t;
    wait_for(0, 40, at);
    chk("send_lat", at - ref_cyc, lat);
    chk("send_counter", sif.counter, s);
    gl = $urandom_range(0, 3);
    repeat (gl) tick();
    sif.new_moves = 1'b1;
    tick();
    sif.new_moves = 1'b0;
    chk("exec_start", sif.exec_start, 1);
    el = $urandom_range(0, 4);
    repeat (el) tick();
    sif.exec_done = 1'b1;
    t = cyc;
    tick();
    sif.exec_done = 1'b0;
    t_out = t;
    if (s == LAST) begin
      chk("scan_done_pulse", scan_done, 1);
      chk("busy_in_done", busy, 1);
      tick();
      chk("scan_done_low", scan_done, 0);
      chk("busy_after_done", busy, 0);
      chk("counter_hold_last", sif.counter, LAST);
      return;
    end
    if (mode == 2) return;
    wait_for(2, SETTLE + 8, at);
    chk("obs_lat", at - t, SETTLE + 1);
    chk("obs_counter", sif.counter, s);
    t_out = at;
    if (mode == 1) return;
    al = $urandom_range(0, 3);
    repeat (al) tick();
    chk("obs_hold", sif.observe_req, 1);
    sif.observe_ack = 1'b1;
    t = cyc;
    tick();
    sif.observe_ack = 1'b0;
    chk("obs_fall", sif.observe_req, 0);
    t_out = t;
  endtask

  task automatic run_steps(input int from, input int to, input int ref_cyc, input int lat, output int last_a);
    int r = ref_cyc, l = lat, a = 0;
    for (int s = from; s <= to; s++) begin
      do_step(s, r, l, 0, a);
      r = a;
      l = 3;
    end
    last_a = a;
  endtask

  initial begin
    int c, a, cs, at, o, snap, snap_o;
    sif.new_moves   = 1'b0;
    sif.exec_done   = 1'b0;
    sif.observe_ack = 1'b0;

    tick();
    tick();
    chk("rst_counter", sif.counter, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_send", sif.send_setup_moves, 0);
    chk("rst_obs", sif.observe_req, 0);
    reset = 1'b0;
    tick();

    // full scan with randomized generator/executor/sensor latencies
    snap = n_send; snap_o = n_obs;
    do_start(c);
    chk("busy_after_start", busy, 1);
    run_steps(0, LAST, c, 2, a);
    tick();
    chk("scan_send_count", n_send - snap, LAST + 1);
    chk("scan_obs_count", n_obs - snap_o, LAST);
    chk("scan_idle", busy, 0);

    // generator never answers at step 3
    do_start(c);
    run_steps(0, 2, c, 2, a);
    wait_for(0, 20, cs);
    chk("to_send_lat", cs - a, 3);
    chk("to_counter", sif.counter, 3);
    wait_for(3, 40, at);
    chk("to_error_lat", at - cs, TMO);
    chk("to_busy", busy, 0);
    chk("to_counter_hold", sif.counter, 3);
    repeat (3) tick();
    chk("to_error_sticky", error, 1);
    do_start(c);
    chk("restart_error_clr", error, 0);
    chk("restart_counter", sif.counter, 0);

    // abort while observing step 10
    run_steps(0, 9, c, 2, a);
    do_step(10, a, 3, 1, o);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_obs", sif.observe_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_counter", sif.counter, 10);
    snap = n_send;
    sif.observe_ack = 1'b1;
    repeat (3) tick();
    sif.observe_ack = 1'b0;
    tick();
    chk("late_ack_counter", sif.counter, 10);
    chk("late_ack_busy", busy, 0);
    chk("late_ack_send", n_send - snap, 0);
    chk("abort_error_held", error, 0);

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    chk("start_abort_busy", busy, 0);
    chk("start_abort_counter", sif.counter, 10);

    // asynchronous reset in the middle of SETTLE
    do_start(c);
    run_steps(0, 1, c, 2, a);
    do_step(2, a, 3, 2, o);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("areset_counter", sif.counter, 0);
    chk("areset_busy", busy, 0);
    chk("areset_send", sif.send_setup_moves, 0);
    chk("areset_exec", sif.exec_start, 0);
    chk("areset_obs", sif.observe_req, 0);
    chk("areset_done", scan_done, 0);
    chk("areset_error", error, 0);
    #2 reset = 1'b0;
    snap = n_send;
    repeat (5) tick();
    chk("post_reset_idle", busy, 0);
    chk("post_reset_nosend", n_send - snap, 0);

    // restart, then hold observe_ack for 5 cycles at step 7
    do_start(c);
    run_steps(0, 6, c, 2, a);
    do_step(7, a, 3, 1, o);
    snap = n_send;
    sif.observe_ack = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) chk("held_ack_obs_fall", sif.observe_req, 0);
    end
    sif.observe_ack = 1'b0;
    chk("held_ack_counter", sif.counter, 8);
    chk("held_ack_sends", n_send - snap, 1);
    chk("held_ack_no_obs", sif.observe_req, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
